// File: rtl/uart_rx_word_ctrl.sv
// Assembles consecutive UART bytes into a little-endian word with a valid/ready
// output handshake, an inter-byte timeout and an overrun flag for bytes dropped while a word is held.
module uart_rx_word_ctrl #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned TIMEOUT_TICKS  = 2048
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  s_tick,
  input  logic                                  rx_done_tick,
  input  logic [DATA_BITS-1:0]                  rx_data,
  input  logic                                  word_ready,
  output logic                                  word_valid,
  output logic [DATA_BITS*BYTES_PER_WORD-1:0]   word_data,
  output logic                                  overrun,
  output logic                                  timeout_err
);

  localparam int unsigned WORD_W = DATA_BITS * BYTES_PER_WORD;
  localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [WORD_W-1:0]  word_data_q, word_data_d;
  logic               word_valid_q, word_valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_err_q, timeout_err_d;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_lane;

  // Next-state, lane write and pulse generation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    word_data_d   = word_data_q;
    overrun_d     = 1'b0;
    timeout_err_d = 1'b0;
    wr_en         = 1'b0;
    wr_lane       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          wr_en   = 1'b1;
          wr_lane = '0;
          cnt_d   = CNT_W'(1);
          tmo_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_done_tick) begin
          wr_en = 1'b1;
          tmo_d = '0;
          if (cnt_q == LAST_LANE) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (s_tick) begin
          if (tmo_q == TMO_LAST) begin
            cnt_d         = '0;
            tmo_d         = '0;
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      HOLD: begin
        // A byte arriving with the handshake starts the next word instead of overrunning
        if (word_ready) begin
          if (rx_done_tick) begin
            wr_en   = 1'b1;
            wr_lane = '0;
            cnt_d   = CNT_W'(1);
            tmo_d   = '0;
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end else if (rx_done_tick) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tmo_d   = '0;
      end
    endcase

    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      if (wr_en && (wr_lane == CNT_W'(k))) begin
        word_data_d[k*DATA_BITS +: DATA_BITS] = rx_data;
      end
    end

    word_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tmo_q         <= '0;
      word_data_q   <= '0;
      word_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      word_data_q   <= word_data_d;
      word_valid_q  <= word_valid_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign word_valid  = word_valid_q;
  assign word_data   = word_data_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
